// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the memory-access stage (master)
// and the data memory or bus fabric (slave).
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: lane steering, load extension, alignment and
// bus-timeout checks, with a registered valid/ready result toward write-back.
module mem_access_stage #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_alu_result,
  input  logic [31:0]                in_store_data,
  input  logic                       in_mem_read,
  input  logic                       in_mem_write,
  input  logic [1:0]                 in_size,
  input  logic                       in_unsigned,
  input  logic [4:0]                 in_rd,
  input  logic                       in_reg_write,
  mem_access_stage_if.master         dmem,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [4:0]                 out_rd,
  output logic                       out_reg_write,
  output logic                       out_exc_misalign,
  output logic                       out_exc_bus
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [0:0]  state_reg, state_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic        kill_reg, kill_next;

  logic        req_reg, req_next;
  logic        we_reg, we_next;
  logic [31:0] addr_reg, addr_next;
  logic [3:0]  be_reg, be_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [1:0]  size_reg, size_next;
  logic        unsigned_reg, unsigned_next;
  logic [4:0]  rd_reg, rd_next;
  logic        reg_write_reg, reg_write_next;

  logic        out_valid_reg, out_valid_next;
  logic [31:0] out_result_reg, out_result_next;
  logic [4:0]  out_rd_reg, out_rd_next;
  logic        out_reg_write_reg, out_reg_write_next;
  logic        out_mis_reg, out_mis_next;
  logic        out_bus_reg, out_bus_next;

  logic        hold;
  logic        accept;
  logic        is_mem;
  logic        misaligned;
  logic        misalign_hit;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [7:0]  rd_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_val;
  logic        ack_hit;
  logic        timeout;

  assign hold     = out_valid_reg && !out_ready;
  assign in_ready = (state_reg == ST_IDLE) && !hold;
  // flush suppresses capture of an instruction offered in the same cycle
  assign accept   = in_valid && in_ready && !flush;
  assign is_mem   = in_mem_read || in_mem_write;

  always_comb begin
    misaligned = 1'b0;
    be_calc    = 4'b1111;
    case (in_size)
      2'b00: begin
        misaligned = 1'b0;
        be_calc    = 4'b0001 << in_alu_result[1:0];
      end
      2'b01: begin
        misaligned = in_alu_result[0];
        be_calc    = 4'b0011 << in_alu_result[1:0];
      end
      default: begin
        misaligned = |in_alu_result[1:0];
        be_calc    = 4'b1111;
      end
    endcase
  end

  assign misalign_hit = is_mem && misaligned;

  // Store data replicated across lanes so the enabled lanes see the right bytes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    always_comb begin
      case (in_size)
        2'b00:   wdata_calc[gi*8 +: 8] = in_store_data[7:0];
        2'b01:   wdata_calc[gi*8 +: 8] = in_store_data[(gi%2)*8 +: 8];
        default: wdata_calc[gi*8 +: 8] = in_store_data[gi*8 +: 8];
      endcase
    end
    assign rd_byte[gi] = dmem.dmem_rdata[gi*8 +: 8];
  end

  assign sel_byte = rd_byte[addr_reg[1:0]];
  assign sel_half = addr_reg[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

  always_comb begin
    case (size_reg)
      2'b00:   load_val = unsigned_reg ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      2'b01:   load_val = unsigned_reg ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: load_val = dmem.dmem_rdata;
    endcase
  end

  // An ack in the final allowed cycle takes priority over the timeout.
  assign ack_hit = (state_reg == ST_ACCESS) && dmem.dmem_ack;
  assign timeout = (state_reg == ST_ACCESS) && !dmem.dmem_ack && (wait_cnt_reg == WAIT_LAST);

  always_comb begin
    state_next         = state_reg;
    wait_cnt_next      = wait_cnt_reg;
    kill_next          = kill_reg;
    req_next           = req_reg;
    we_next            = we_reg;
    addr_next          = addr_reg;
    be_next            = be_reg;
    wdata_next         = wdata_reg;
    size_next          = size_reg;
    unsigned_next      = unsigned_reg;
    rd_next            = rd_reg;
    reg_write_next     = reg_write_reg;
    out_valid_next     = out_valid_reg;
    out_result_next    = out_result_reg;
    out_rd_next        = out_rd_reg;
    out_reg_write_next = out_reg_write_reg;
    out_mis_next       = out_mis_reg;
    out_bus_next       = out_bus_reg;

    if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (!is_mem || misalign_hit) begin
            out_valid_next     = 1'b1;
            out_result_next    = in_alu_result;
            out_rd_next        = in_rd;
            out_reg_write_next = in_reg_write && !misalign_hit;
            out_mis_next       = misalign_hit;
            out_bus_next       = 1'b0;
          end else begin
            state_next     = ST_ACCESS;
            wait_cnt_next  = 8'd0;
            kill_next      = 1'b0;
            req_next       = 1'b1;
            we_next        = in_mem_write;
            addr_next      = in_alu_result;
            be_next        = be_calc;
            wdata_next     = wdata_calc;
            size_next      = in_size;
            unsigned_next  = in_unsigned;
            rd_next        = in_rd;
            reg_write_next = in_reg_write;
          end
        end
      end
      default: begin
        if (ack_hit || timeout) begin
          state_next    = ST_IDLE;
          req_next      = 1'b0;
          wait_cnt_next = 8'd0;
          kill_next     = 1'b0;
          if (!(kill_reg || flush)) begin
            out_valid_next = 1'b1;
            out_rd_next    = rd_reg;
            out_mis_next   = 1'b0;
            out_bus_next   = !ack_hit;
            if (ack_hit && !we_reg) begin
              out_result_next    = load_val;
              out_reg_write_next = reg_write_reg;
            end else begin
              out_result_next    = addr_reg;
              out_reg_write_next = 1'b0;
            end
          end
        end else begin
          // The bus transaction is never abandoned; a flush only marks it dead.
          wait_cnt_next = wait_cnt_reg + 8'd1;
          if (flush) begin
            kill_next = 1'b1;
          end
        end
      end
    endcase

    if (flush) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg         <= ST_IDLE;
      wait_cnt_reg      <= 8'd0;
      kill_reg          <= 1'b0;
      req_reg           <= 1'b0;
      we_reg            <= 1'b0;
      addr_reg          <= 32'h0;
      be_reg            <= 4'h0;
      wdata_reg         <= 32'h0;
      size_reg          <= 2'b00;
      unsigned_reg      <= 1'b0;
      rd_reg            <= 5'd0;
      reg_write_reg     <= 1'b0;
      out_valid_reg     <= 1'b0;
      out_result_reg    <= 32'h0;
      out_rd_reg        <= 5'd0;
      out_reg_write_reg <= 1'b0;
      out_mis_reg       <= 1'b0;
      out_bus_reg       <= 1'b0;
    end else begin
      state_reg         <= state_next;
      wait_cnt_reg      <= wait_cnt_next;
      kill_reg          <= kill_next;
      req_reg           <= req_next;
      we_reg            <= we_next;
      addr_reg          <= addr_next;
      be_reg            <= be_next;
      wdata_reg         <= wdata_next;
      size_reg          <= size_next;
      unsigned_reg      <= unsigned_next;
      rd_reg            <= rd_next;
      reg_write_reg     <= reg_write_next;
      out_valid_reg     <= out_valid_next;
      out_result_reg    <= out_result_next;
      out_rd_reg        <= out_rd_next;
      out_reg_write_reg <= out_reg_write_next;
      out_mis_reg       <= out_mis_next;
      out_bus_reg       <= out_bus_next;
    end
  end

  assign dmem.dmem_req   = req_reg;
  assign dmem.dmem_we    = we_reg;
  assign dmem.dmem_addr  = {addr_reg[31:2], 2'b00};
  assign dmem.dmem_be    = be_reg;
  assign dmem.dmem_wdata = wdata_reg;

  assign out_valid        = out_valid_reg;
  assign out_result       = out_result_reg;
  assign out_rd           = out_rd_reg;
  assign out_reg_write    = out_reg_write_reg;
  assign out_exc_misalign = out_mis_reg;
  assign out_exc_bus      = out_bus_reg;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the EX-stage ALU: consumes alu_result as a load/store effective address or as a pass-through result.
- Drives a variable-latency data-memory request/acknowledge port.
- Performs byte-lane steering, load sign/zero extension, alignment checking and bus-timeout detection.
- Presents a registered result to write-back over a valid/ready handshake, and stalls upstream while a memory access is outstanding.

Parameters:
- MAX_WAIT, 255: cycles `dmem_req` may stay high without `dmem_ack` before a bus error is declared; range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of the in-flight/held instruction
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept an instruction this cycle
- in_alu_result  in  32  ALU output: effective address or result
- in_store_data  in  32  rt value for stores
- in_mem_read  in  1  load instruction
- in_mem_write  in  1  store instruction
- in_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- in_unsigned  in  1  zero-extend loads (LBU/LHU)
- in_rd  in  5  destination register
- in_reg_write  in  1  instruction writes rd
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, bits [1:0] = 0
- dmem_be  out  4  byte enables, bit i = byte lane i (little-endian)
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  request completed this cycle
- dmem_rdata  in  32  read data, valid when dmem_ack
- out_valid  out  1  result valid to write-back
- out_ready  in  1  write-back accepts result
- out_result  out  32  loaded value or pass-through ALU result
- out_rd  out  5  destination register
- out_reg_write  out  1  write enable, forced 0 on exception
- out_exc_misalign  out  1  misaligned access
- out_exc_bus  out  1  bus timeout

Behaviour:
- Reset (rstn=0, asynchronous):
  - State to IDLE; wait counter and kill flag to 0.
  - All outputs 0 except `in_ready`, which follows its equation, giving 1.
- State machine: IDLE, ACCESS.
  - `in_ready` = (state==IDLE) && !(out_valid && !out_ready).
  - Accept = in_valid && in_ready.
- Accept of a non-memory op (mem_read=mem_write=0):
  - Next edge: out_valid=1, out_result=in_alu_result, rd and reg_write copied, exception bits 0.
  - Latency 1. State stays IDLE.
- Alignment check on a memory-op accept: half needs addr[0]=0; word/reserved needs addr[1:0]=0.
- Misaligned memory op:
  - Next edge: out_valid=1, out_exc_misalign=1, out_reg_write=0, out_result=in_alu_result (bad address).
  - No memory request is issued.
- Aligned memory op:
  - Latch all inputs; next edge: state ACCESS, dmem_req=1.
  - dmem_addr={addr[31:2],2'b00}, dmem_we=mem_write.
  - dmem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
  - dmem_wdata: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
  - Request signals stay stable until acknowledged or timed out.
- In ACCESS, `dmem_ack` is sampled each cycle with `dmem_req` high. On ack:
  - dmem_req drops at the next edge; state returns to IDLE; out_valid=1 at that same edge.
  - Load: selected byte/half at lane addr[1:0]*8, sign-extended unless in_unsigned.
  - Store: out_result = address, out_reg_write=0.
  - Minimum load/store latency is 2 cycles (accept edge → req; ack edge → out_valid).
- Wait counter:
  - Counts cycles with req high and no ack.
  - If it reaches MAX_WAIT: drop req, return to IDLE, out_valid=1, out_exc_bus=1, out_reg_write=0.
  - An ack arriving in the same cycle as the timeout wins.
- Output register holds all out_* stable while out_valid && !out_ready.
  - Handshake completes on out_valid && out_ready; out_valid clears unless a new result loads the same edge.
  - Back-to-back throughput is 1 per cycle for non-memory ops.
- flush:
  - Clears out_valid at the next edge.
  - In IDLE, it blocks any load or capture of an accept that occurs in the same cycle.
  - In ACCESS, a bus request is never abandoned: the transaction runs to ack or timeout, a kill flag is set, and the result is discarded (out_valid stays 0).
- Reset mid-ACCESS: dmem_req falls immediately (asynchronous); no result is produced.

Test Plan:
- ADDU result 0x0000_1234, rd=8, no mem op → out_valid one cycle after accept, out_result=0x1234, out_rd=8, out_reg_write=1, no dmem_req.
- LB, addr 0x103, signed, memory acks after 3 cycles with rdata 0x80FF_0000 → dmem_addr=0x100, be=0001<<3=1000, out_result=0xFFFF_FF80; same with LBU → 0x0000_0080.
- SH, addr 0x22, data 0xABCD_5678 → dmem_we=1, be=1100, wdata=0x5678_5678, out_reg_write=0; LW at 0x22 → out_exc_misalign=1, no dmem_req.
- MAX_WAIT=4, ack never given → dmem_req high exactly 4 cycles, then out_exc_bus=1, out_reg_write=0, in_ready returns to 1.
- out_ready=0 for 5 cycles while holding a result, with in_valid=1 → in_ready=0 and out_* stable; next accept only after the handshake.
- flush asserted in the 2nd ACCESS cycle, ack in the 3rd → req held until ack, no out_valid. Separately, rstn pulsed low mid-ACCESS → dmem_req drops without a clock edge.
